// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer: accepts one block instruction and emits one memory beat per
// register in the list under valid/ready, then pulses done with the base writeback value.
module ldm_stm_sequencer #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned TAG_W  = 4
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              start_in,
  output logic              ready_out,
  output logic              busy_out,
  input  logic              instr_exec_in,
  input  logic [TAG_W-1:0]  instr_tag_in,
  input  logic              load_in,
  input  logic [15:0]       reg_list_in,
  input  logic [ADDR_W-1:0] base_addr_in,
  input  logic              pre_index_in,
  input  logic              up_in,
  input  logic              writeback_in,
  output logic              beat_valid_out,
  input  logic              beat_ready_in,
  output logic [ADDR_W-1:0] beat_addr_out,
  output logic [3:0]        beat_reg_out,
  output logic              beat_load_out,
  output logic              beat_last_out,
  output logic [TAG_W-1:0]  beat_tag_out,
  output logic              done_out,
  output logic              wb_en_out,
  output logic [ADDR_W-1:0] wb_addr_out
);

  typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

  state_e            state_q;
  logic [15:0]       list_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] wb_addr_q;
  logic [TAG_W-1:0]  tag_q;
  logic              load_q;
  logic              wb_en_q;

  logic [4:0]        pop;
  logic [ADDR_W-1:0] span;
  logic [ADDR_W-1:0] start_addr;
  logic [3:0]        low_reg;
  logic              one_left;

  always_comb begin
    pop = '0;
    for (int i = 0; i < 16; i++) begin
      pop = pop + 5'(reg_list_in[i]);
    end
  end

  assign span = ADDR_W'(pop) << 2;

  // Lowest register always lands at the lowest address, so decrement modes start below base.
  always_comb begin
    unique case ({pre_index_in, up_in})
      2'b01:   start_addr = base_addr_in;
      2'b11:   start_addr = base_addr_in + ADDR_W'(4);
      2'b00:   start_addr = base_addr_in - span + ADDR_W'(4);
      default: start_addr = base_addr_in - span;
    endcase
  end

  always_comb begin
    low_reg = '0;
    for (int i = 15; i >= 0; i--) begin
      if (list_q[i]) low_reg = 4'(i);
    end
  end

  assign one_left = (list_q != 16'd0) && ((list_q & (list_q - 16'd1)) == 16'd0);

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q   <= StIdle;
      list_q    <= '0;
      addr_q    <= '0;
      wb_addr_q <= '0;
      tag_q     <= '0;
      load_q    <= 1'b0;
      wb_en_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_in) begin
            tag_q     <= instr_tag_in;
            load_q    <= load_in;
            wb_addr_q <= up_in ? base_addr_in + span : base_addr_in - span;
            if (instr_exec_in && (pop != 5'd0)) begin
              list_q  <= reg_list_in;
              addr_q  <= start_addr;
              wb_en_q <= writeback_in;
              state_q <= StXfer;
            end else begin
              list_q  <= '0;
              wb_en_q <= 1'b0;
              state_q <= StDone;
            end
          end
        end
        StXfer: begin
          if (beat_ready_in) begin
            list_q <= list_q & (list_q - 16'd1);
            addr_q <= addr_q + ADDR_W'(4);
            if (one_left) state_q <= StDone;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ready_out      = (state_q == StIdle);
  assign busy_out       = ~ready_out;
  assign beat_valid_out = (state_q == StXfer);
  assign beat_last_out  = beat_valid_out && one_left;
  assign beat_addr_out  = addr_q;
  assign beat_reg_out   = low_reg;
  assign beat_load_out  = load_q;
  assign beat_tag_out   = tag_q;
  assign done_out       = (state_q == StDone);
  assign wb_en_out      = done_out && wb_en_q;
  assign wb_addr_out    = wb_addr_q;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Randomized bench for ldm_stm_sequencer against a queue-based model of the beat sequence.
module tb_ldm_stm_sequencer;

  logic        clk = 1'b0;
  logic        reset_in;
  logic        start_in;
  logic        ready_out;
  logic        busy_out;
  logic        instr_exec_in;
  logic [3:0]  instr_tag_in;
  logic        load_in;
  logic [15:0] reg_list_in;
  logic [31:0] base_addr_in;
  logic        pre_index_in;
  logic        up_in;
  logic        writeback_in;
  logic        beat_valid_out;
  logic        beat_ready_in;
  logic [31:0] beat_addr_out;
  logic [3:0]  beat_reg_out;
  logic        beat_load_out;
  logic        beat_last_out;
  logic [3:0]  beat_tag_out;
  logic        done_out;
  logic        wb_en_out;
  logic [31:0] wb_addr_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ldm_stm_sequencer #(.ADDR_W(32), .TAG_W(4)) dut (
    .clk_in(clk), .reset_in(reset_in), .start_in(start_in), .ready_out(ready_out),
    .busy_out(busy_out), .instr_exec_in(instr_exec_in), .instr_tag_in(instr_tag_in),
    .load_in(load_in), .reg_list_in(reg_list_in), .base_addr_in(base_addr_in),
    .pre_index_in(pre_index_in), .up_in(up_in), .writeback_in(writeback_in),
    .beat_valid_out(beat_valid_out), .beat_ready_in(beat_ready_in),
    .beat_addr_out(beat_addr_out), .beat_reg_out(beat_reg_out), .beat_load_out(beat_load_out),
    .beat_last_out(beat_last_out), .beat_tag_out(beat_tag_out), .done_out(done_out),
    .wb_en_out(wb_en_out), .wb_addr_out(wb_addr_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_inputs;
    instr_tag_in  = 4'($urandom);
    load_in       = 1'($urandom);
    reg_list_in   = 16'($urandom);
    base_addr_in  = $urandom;
    pre_index_in  = 1'($urandom);
    up_in         = 1'($urandom);
    writeback_in  = 1'($urandom);
    instr_exec_in = 1'($urandom);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_ready"}, ready_out, 1);
    check({pfx, "_busy"}, busy_out, 0);
    check({pfx, "_valid"}, beat_valid_out, 0);
    check({pfx, "_last"}, beat_last_out, 0);
    check({pfx, "_done"}, done_out, 0);
    check({pfx, "_wb_en"}, wb_en_out, 0);
    check({pfx, "_addr"}, beat_addr_out, 0);
    check({pfx, "_reg"}, beat_reg_out, 0);
    check({pfx, "_tag"}, beat_tag_out, 0);
    check({pfx, "_load"}, beat_load_out, 0);
    check({pfx, "_wb_addr"}, wb_addr_out, 0);
  endtask

  // mode 0: ready always high; 1: random ready; 2: ready low for the first `stall` cycles
  task automatic run(input logic [15:0] list, input logic [31:0] base, input bit p, input bit u,
                     input bit w, input bit exec, input int mode, input int stall);
    int          n;
    int          cyc;
    int          waited;
    bit          r;
    bit          has_beats;
    logic [31:0] step4;
    logic [31:0] lo;
    logic [31:0] wb;
    logic [3:0]  tag;
    bit          ld;
    int          regs[$];
    logic [31:0] addrs[$];

    n     = $countones(list);
    step4 = 32'(4 * n);
    if (u) lo = p ? base + 32'd4 : base;
    else   lo = p ? base - step4 : base - step4 + 32'd4;
    wb = u ? base + step4 : base - step4;
    for (int k = 0; k < 16; k++) begin
      if (list[k]) begin
        addrs.push_back(lo + 32'(4 * regs.size()));
        regs.push_back(k);
      end
    end
    has_beats = exec && (n > 0);
    tag = 4'($urandom);
    ld  = 1'($urandom);

    waited = 0;
    while (!ready_out && waited < 50) begin
      tick;
      waited++;
    end
    check("ready_before_start", ready_out, 1);

    start_in      = 1'b1;
    instr_tag_in  = tag;
    load_in       = ld;
    reg_list_in   = list;
    base_addr_in  = base;
    pre_index_in  = p;
    up_in         = u;
    writeback_in  = w;
    instr_exec_in = exec;
    beat_ready_in = 1'($urandom);
    tick;
    start_in = 1'b0;
    scramble_inputs();

    cyc = 0;
    if (has_beats) begin
      while (regs.size() > 0 && cyc < 300) begin
        check("beat_valid", beat_valid_out, 1);
        check("beat_busy", busy_out, 1);
        check("beat_ready_out", ready_out, 0);
        check("beat_done", done_out, 0);
        check("beat_addr", beat_addr_out, addrs[0]);
        check("beat_reg", beat_reg_out, 32'(regs[0]));
        check("beat_last", beat_last_out, 32'(regs.size() == 1));
        check("beat_tag", beat_tag_out, tag);
        check("beat_load", beat_load_out, ld);
        case (mode)
          0:       r = 1'b1;
          2:       r = (cyc >= stall);
          default: r = 1'($urandom);
        endcase
        beat_ready_in = r;
        tick;
        cyc++;
        if (r) begin
          void'(regs.pop_front());
          void'(addrs.pop_front());
        end
      end
      check("beats_drained", 32'(regs.size()), 0);
      if (mode == 0) check("zero_bp_latency", cyc, n);
    end

    check("done_pulse", done_out, 1);
    check("done_valid", beat_valid_out, 0);
    check("done_ready", ready_out, 0);
    check("wb_en", wb_en_out, 32'(w && has_beats));
    check("wb_addr", wb_addr_out, wb);

    // A start presented during DONE must be ignored.
    start_in      = 1'b1;
    instr_exec_in = 1'b1;
    reg_list_in   = 16'hFFFF;
    beat_ready_in = 1'($urandom);
    tick;
    start_in = 1'b0;
    check("idle_ready", ready_out, 1);
    check("idle_done", done_out, 0);
    check("idle_valid", beat_valid_out, 0);
    tick;
    check("ignored_start_valid", beat_valid_out, 0);
    check("ignored_start_ready", ready_out, 1);
  endtask

  task automatic reset_mid_transfer;
    start_in      = 1'b1;
    instr_tag_in  = 4'hA;
    load_in       = 1'b1;
    reg_list_in   = 16'h00FF;
    base_addr_in  = 32'h0000_4000;
    pre_index_in  = 1'b0;
    up_in         = 1'b1;
    writeback_in  = 1'b1;
    instr_exec_in = 1'b1;
    beat_ready_in = 1'b1;
    tick;
    start_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("rst_beat_addr", beat_addr_out, 32'h4000 + 32'(4 * k));
      check("rst_beat_reg", beat_reg_out, k);
      tick;
    end
    reset_in = 1'b1;
    tick;
    reset_in = 1'b0;
    check_reset_outputs("midrst");
    tick;
    check("midrst_no_done", done_out, 0);
    check("midrst_no_valid", beat_valid_out, 0);
    check("midrst_idle", ready_out, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_in      = 1'b1;
    start_in      = 1'b0;
    beat_ready_in = 1'b0;
    scramble_inputs();
    tick;
    tick;
    reset_in = 1'b0;
    check_reset_outputs("reset");

    run(16'h000F, 32'h0000_1000, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0);
    run(16'h8001, 32'h0000_2000, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0);
    run(16'h0006, 32'h0000_3000, 1'b0, 1'b0, 1'b0, 1'b1, 2, 3);
    run(16'hFFFF, 32'h0000_5000, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    run(16'h0000, 32'h0000_6000, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0);
    run(16'h0003, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0);
    reset_mid_transfer();
    run(16'h00FF, 32'h0000_4000, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0);

    for (int t = 0; t < 60; t++) begin
      logic [15:0] l;
      l = 16'($urandom);
      if ($urandom_range(0, 7) == 0) l = 16'h0000;
      else if ($urandom_range(0, 3) == 0) l = 16'(1 << $urandom_range(0, 15));
      run(l, $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
          ($urandom_range(0, 5) != 0), $urandom_range(0, 2), $urandom_range(0, 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
